multicycle_datapath: RTL
========================

// Module: multicycle_datapath
// PURPOSE
//  Parametrised multi-cycle successor of the single-cycle 16-bit datapath.
//  Runs each instruction over 3-5 states under an internal FSM and shares one ALU.
//  Talks to external instruction and data memories through req/ready handshakes, so wait states are tolerated.
//  Sits under the CPU top; the existing CU still decodes opcode into the same control bits.
// PARAMETERS
//  DATA_W    16   register/ALU/data-memory word width (>=16)
//  ADDR_W    16   PC and memory address width
//  REG_AW    2    register index width; file holds 2**REG_AW registers
//  PC_RESET  10   PC value loaded on reset
// PORTS
//  Clock        in   1       rising-edge clock
//  Resetn       in   1       synchronous, active-low reset
//  RegDst,Branch,MemRead,MemWrite,RegWrite,MemToReg,ALUSrc  in 1  CU controls, sampled in DECODE onward
//  ALUOp        in   2       00 add, 01 sub, 10 R-type by funct, 11 shift-left by shamt
//  opcode       out  4       IR[15:12] to CU
//  imem_req     out  1       instruction fetch request
//  imem_addr    out  ADDR_W  fetch address (=PC)
//  imem_rdata   in   16      instruction word
//  imem_ready   in   1       fetch complete this cycle
//  dmem_req     out  1       data access request
//  dmem_we      out  1       1=store, 0=load
//  dmem_addr    out  ADDR_W  ALUOut[ADDR_W-1:0]
//  dmem_wdata   out  DATA_W  B latch (rt)
//  dmem_rdata   in   DATA_W  load data
//  dmem_ready   in   1       data access complete this cycle
//  retire       out  1       1-cycle pulse when an instruction completes
//  perf_cycles  out  32      cycles since reset (optional feature)
//  perf_retired out  32      instructions retired (optional feature)
// BEHAVIOUR
//  IR fields: op[15:12] rs[11:10] rt[9:8] rd[7:6] shamt[5:2] funct[1:0] imm[7:0].
//  imm is sign-extended to DATA_W. funct: 00 add, 01 sub, 10 and, 11 or.
//  FSM states:
//   FETCH: imem_req=1. On imem_ready, IR<=imem_rdata and PC<=PC+2 -> DECODE.
//   DECODE: A<=R[rs], B<=R[rt] -> EXEC.
//   EXEC: ALUOut<=A op (ALUSrc ? simm : B).
//    Branch: if zero, PC<=PC+(simm<<1); retire; -> FETCH.
//    MemRead|MemWrite -> MEM. RegWrite -> WB. Otherwise retire and -> FETCH.
//   MEM: dmem_req=1, dmem_we=MemWrite.
//    On dmem_ready: load -> MDR<=dmem_rdata, -> WB; store -> retire, -> FETCH.
//   WB: R[RegDst?rd:rt] <= MemToReg ? MDR : ALUOut; retire; -> FETCH.
//  Minimum latency (zero-wait memory): beq 3, R/addi 4, sw 4, lw 5 cycles.
//  Handshakes:
//   - Ready is sampled only while req=1.
//   - Ready in the same cycle as req is legal.
//   - req, addr, wdata and we are held stable until ready.
//  Arithmetic:
//   - ALU and PC wrap modulo 2**DATA_W and 2**ADDR_W; no traps.
//   - zero = (ALU result == 0).
//   - Branch target is computed from the already-incremented PC.
//  Write to the register that is also a source takes effect for the next instruction only.
//  Reset (Resetn=0 at an edge), including mid-operation:
//   - state=FETCH, PC=PC_RESET, all registers, IR, A, B, ALUOut, MDR = 0.
//   - imem_req, dmem_req, dmem_we, retire = 0. Any outstanding memory request is abandoned.
//  First fetch after reset is issued the cycle after Resetn rises.
// CONFIGURATION
//  DATAPATH_PERF_CNT_EN defined:
//   - perf_cycles increments every non-reset cycle; perf_retired increments on retire.
//   - Both are 32-bit, wrap, and clear on reset.
//  Not defined: perf_cycles and perf_retired are tied to 0 and no counter logic exists.
// STRUCTURE
//  Package datapath_pkg: state encoding (FETCH..WB), ALUOp codes, funct codes, IR field bit positions, instruction byte size (2).
//  Sub-module mc_alu: DATA_W combinational ALU (op, shamt -> result, zero). FSM, register file and latches stay in this module.
// TESTING
//  1. Reset with Resetn=0 for 2 cycles -> first imem_addr=10, imem_req=1; all outputs low.
//  2. Zero-wait R-type add: R1=5, R2=7, rd=3 -> R3=12 after 4 cycles; retire pulses once; next imem_addr=12.
//  3. lw with dmem_ready delayed 3 cycles: dmem_addr/dmem_we held stable; dmem_rdata=0xBEEF -> rt=0xBEEF; 8 cycles total.
//  4. beq with equal regs and imm=0xFE at PC=20 -> next PC=18; with unequal regs -> next PC=22.
//  5. Resetn low while in MEM with dmem_req=1 -> next cycle dmem_req=0, state FETCH, PC=10.
//  6. With DATAPATH_PERF_CNT_EN: 3 zero-wait add instructions -> perf_retired=3, perf_cycles=12; without the macro, both read 0.

Source files
------------

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared encodings for the multi-cycle datapath and its ALU.
package datapath_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_SHL   = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_SUB = 2'b01,
        FN_AND = 2'b10,
        FN_OR  = 2'b11
    } funct_t;

    // Instruction word field positions
    localparam int unsigned IR_W         = 16;
    localparam int unsigned IR_OP_LSB    = 12;
    localparam int unsigned IR_OP_W      = 4;
    localparam int unsigned IR_RS_LSB    = 10;
    localparam int unsigned IR_RT_LSB    = 8;
    localparam int unsigned IR_RD_LSB    = 6;
    localparam int unsigned IR_RIDX_W    = 2;
    localparam int unsigned IR_SHAMT_LSB = 2;
    localparam int unsigned IR_SHAMT_W   = 4;
    localparam int unsigned IR_FUNCT_LSB = 0;
    localparam int unsigned IR_FUNCT_W   = 2;
    localparam int unsigned IR_IMM_LSB   = 0;
    localparam int unsigned IR_IMM_W     = 8;

    // Bytes per instruction; PC advances by this on every fetch
    localparam int unsigned INSTR_BYTES  = 2;

endpackage

// File: rtl/mc_alu.sv
// mc_alu: combinational ALU shared by all instruction classes.
module mc_alu
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [1:0]            i_op,
    input  logic [IR_FUNCT_W-1:0] i_funct,
    input  logic [IR_SHAMT_W-1:0] i_shamt,
    input  logic [DATA_W-1:0]     i_a,
    input  logic [DATA_W-1:0]     i_b,
    output logic [DATA_W-1:0]     o_result,
    output logic                  o_zero
);

    logic [DATA_W-1:0] w_res;

    // Select the operation from ALUOp, falling through to funct for R-type
    always_comb begin
        w_res = '0;
        case (i_op)
            ALU_ADD: w_res = i_a + i_b;
            ALU_SUB: w_res = i_a - i_b;
            ALU_FUNCT: begin
                case (i_funct)
                    FN_ADD:  w_res = i_a + i_b;
                    FN_SUB:  w_res = i_a - i_b;
                    FN_AND:  w_res = i_a & i_b;
                    default: w_res = i_a | i_b;
                endcase
            end
            default: w_res = i_a << i_shamt;
        endcase
    end

    assign o_result = w_res;
    assign o_zero   = (w_res == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: FETCH/DECODE/EXEC/MEM/WB sequencing around one shared ALU,
// with req/ready handshakes to instruction and data memories.
// Optional feature macro: DATAPATH_PERF_CNT_EN (cycle and retired-instruction counters).
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned REG_AW   = 2,
    parameter int unsigned PC_RESET = 10
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              RegDst,
    input  logic              Branch,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic              ALUSrc,
    input  logic [1:0]        ALUOp,
    output logic [3:0]        opcode,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              retire,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_retired
);

    localparam int unsigned NREGS = 2 ** REG_AW;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [IR_W-1:0]     r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_aluout;
    logic [DATA_W-1:0]   r_mdr;
    logic [DATA_W-1:0]   r_regs [NREGS];
    logic                r_imem_req;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic                r_retire;

    logic [REG_AW-1:0]   w_rs;
    logic [REG_AW-1:0]   w_rt;
    logic [REG_AW-1:0]   w_rd;
    logic [REG_AW-1:0]   w_wb_idx;
    logic [DATA_W-1:0]   w_simm;
    logic [DATA_W-1:0]   w_opnd;
    logic [DATA_W-1:0]   w_alu_res;
    logic                w_zero;
    logic [DATA_W-1:0]   w_wb_data;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [ADDR_W-1:0]   w_br_off;

    assign w_rs      = REG_AW'(r_ir[IR_RS_LSB +: IR_RIDX_W]);
    assign w_rt      = REG_AW'(r_ir[IR_RT_LSB +: IR_RIDX_W]);
    assign w_rd      = REG_AW'(r_ir[IR_RD_LSB +: IR_RIDX_W]);
    assign w_wb_idx  = RegDst ? w_rd : w_rt;
    assign w_simm    = {{(DATA_W-IR_IMM_W){r_ir[IR_IMM_LSB+IR_IMM_W-1]}}, r_ir[IR_IMM_LSB +: IR_IMM_W]};
    assign w_opnd    = ALUSrc ? w_simm : r_b;
    assign w_wb_data = MemToReg ? r_mdr : r_aluout;
    assign w_pc_inc  = r_pc + ADDR_W'(INSTR_BYTES);
    // Halfword-scaled, sign-extended branch displacement
    assign w_br_off  = {{(ADDR_W-IR_IMM_W-1){r_ir[IR_IMM_LSB+IR_IMM_W-1]}}, r_ir[IR_IMM_LSB +: IR_IMM_W], 1'b0};

    mc_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_op     (ALUOp),
        .i_funct  (r_ir[IR_FUNCT_LSB +: IR_FUNCT_W]),
        .i_shamt  (r_ir[IR_SHAMT_LSB +: IR_SHAMT_W]),
        .i_a      (r_a),
        .i_b      (w_opnd),
        .o_result (w_alu_res),
        .o_zero   (w_zero)
    );

    // Instruction sequencer, register file and datapath latches with registered handshake outputs
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= S_FETCH;
            r_pc       <= ADDR_W'(PC_RESET);
            r_ir       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_aluout   <= '0;
            r_mdr      <= '0;
            r_imem_req <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_retire   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_imem_req <= 1'b1;
                    if (r_imem_req && imem_ready) begin
                        r_ir       <= imem_rdata;
                        r_pc       <= w_pc_inc;
                        r_imem_req <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a     <= r_regs[w_rs];
                    r_b     <= r_regs[w_rt];
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_aluout <= w_alu_res;
                    if (Branch && w_zero) begin
                        r_pc       <= r_pc + w_br_off;
                        r_retire   <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end else if (MemRead || MemWrite) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= MemWrite;
                        r_state    <= S_MEM;
                    end else if (RegWrite) begin
                        r_state <= S_WB;
                    end else begin
                        r_retire   <= 1'b1;
                        r_imem_req <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (r_dmem_we) begin
                            r_retire   <= 1'b1;
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end else begin
                            r_mdr   <= dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_regs[w_wb_idx] <= w_wb_data;
                    r_retire         <= 1'b1;
                    r_imem_req       <= 1'b1;
                    r_state          <= S_FETCH;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign opcode     = r_ir[IR_OP_LSB +: IR_OP_W];
    assign imem_req   = r_imem_req;
    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_aluout[ADDR_W-1:0];
    assign dmem_wdata = r_b;
    assign retire     = r_retire;

`ifdef DATAPATH_PERF_CNT_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_retired;

    // Free-running cycle count and count of completed retire pulses
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_perf_cycles  <= '0;
            r_perf_retired <= '0;
        end else begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
            if (r_retire) begin
                r_perf_retired <= r_perf_retired + 32'd1;
            end
        end
    end

    assign perf_cycles  = r_perf_cycles;
    assign perf_retired = r_perf_retired;
`else
    assign perf_cycles  = '0;
    assign perf_retired = '0;
`endif

endmodule
